hilo_multu_unit: RTL and testbench

Sequential 32-bit unsigned shift-add multiplier that owns the HI and LO registers of the MIPS datapath. It sits directly upstream of the ALU result mux. It accepts a MULTU command from the decode/execute stage and computes the 64-bit product over 32 cycles. It presents the stored product on `HiOut`/`LoOut` for the mux to return on MFHI/MFLO.

---
 rtl/hilo_multu_unit_pkg.sv | 28 ++
 rtl/multu_shift_add_dp.sv | 58 +++++
 rtl/hilo_multu_unit.sv | 168 ++++++++++++++++
 tb/tb_hilo_multu_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_multu_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_multu_unit_pkg
// Description : Shared definitions for the HI/LO multiply unit: funct codes
//               (same encodings as the ALU result mux), operand width default
//               and the sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_multu_unit_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int c_width = 32;

    // Instruction funct field encodings.
    localparam logic [5:0] c_funct_multu = 6'b011001;
    localparam logic [5:0] c_funct_mult  = 6'b011000;
    localparam logic [5:0] c_funct_mfhi  = 6'b010000;
    localparam logic [5:0] c_funct_mflo  = 6'b010010;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : hilo_multu_unit_pkg
`default_nettype wire

// File: rtl/multu_shift_add_dp.sv
`default_nettype none
// ============================================================================
// Module      : multu_shift_add_dp
// Description : Shift-add multiplier datapath. Holds the double-width product
//               register {P_hi, P_lo} and the multiplicand, and performs one
//               conditional add + right shift per step. The post-step product
//               is exposed so the owner can capture it on the final step.
// Revision    : 1.0 - initial release
// ============================================================================
module multu_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [WIDTH-1:0]   p_hi_nxt,
    output logic [WIDTH-1:0]   p_lo_nxt
);

    logic [WIDTH-1:0] r_p_hi;
    logic [WIDTH-1:0] r_p_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH:0]   w_sum;

    // Conditional add of the multiplicand into the upper half; the extra bit
    // keeps the carry so it can be shifted back in below.
    always_comb begin
        w_sum = {1'b0, r_p_hi};
        if (r_p_lo[0]) begin
            w_sum = {1'b0, r_p_hi} + {1'b0, r_mcand};
        end
    end

    // {sum, P_lo} >> 1 split into its two halves.
    assign p_hi_nxt = w_sum[WIDTH:1];
    assign p_lo_nxt = {w_sum[0], r_p_lo[WIDTH-1:1]};

    // Product and multiplicand registers: load seeds, step advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_mcand <= '0;
        end else if (load) begin
            r_p_hi  <= '0;
            r_p_lo  <= b_in;
            r_mcand <= a_in;
        end else if (step) begin
            r_p_hi  <= p_hi_nxt;
            r_p_lo  <= p_lo_nxt;
        end
    end

endmodule : multu_shift_add_dp
`default_nettype wire

// File: rtl/hilo_multu_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_multu_unit
// Description : Sequential unsigned multiplier owning the MIPS HI/LO registers.
//               Accepts MULTU, iterates WIDTH shift-add steps, then writes the
//               product to HI/LO and pulses done for one cycle. HI/LO keep the
//               previous result while a multiply is in flight.
//               Optional macro MULT_SIGNED_EN: also accept MULT (signed) by
//               multiplying magnitudes and negating the result when needed.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_multu_unit
    import hilo_multu_unit_pkg::*;
#(
    parameter int WIDTH = c_width
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic [WIDTH-1:0]   HiOut,
    output logic [WIDTH-1:0]   LoOut,
    output logic               busy,
    output logic               done
);

    localparam int               CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_funct_ok;
    logic               w_accept;
    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH-1:0]   w_p_hi_nxt;
    logic [WIDTH-1:0]   w_p_lo_nxt;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [2*WIDTH-1:0] w_result;

    assign w_prod_nxt = {w_p_hi_nxt, w_p_lo_nxt};

`ifdef MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   c_one_w = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] c_one_p = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic r_sign;
    logic w_is_mult;

    assign w_is_mult  = (funct == c_funct_mult);
    assign w_funct_ok = (funct == c_funct_multu) || w_is_mult;
    // Signed operands enter the datapath as magnitudes.
    assign w_op_a     = (w_is_mult && dataA[WIDTH-1]) ? (~dataA + c_one_w) : dataA;
    assign w_op_b     = (w_is_mult && dataB[WIDTH-1]) ? (~dataB + c_one_w) : dataB;
    assign w_result   = r_sign ? (~w_prod_nxt + c_one_p) : w_prod_nxt;

    // Result sign captured with the operands; always positive for MULTU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
        end else if (w_load) begin
            r_sign <= w_is_mult & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
        end
    end
`else
    assign w_funct_ok = (funct == c_funct_multu);
    assign w_op_a     = dataA;
    assign w_op_b     = dataB;
    assign w_result   = w_prod_nxt;
`endif

    // A command is taken in IDLE or DONE; commands during RUN are dropped.
    assign w_accept = start && w_funct_ok && (r_state != ST_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_DONE;
                    w_finish    = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Iteration counter: cleared on load, advanced once per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // HI/LO capture the post-final-step product; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_finish) begin
            r_hi <= w_result[2*WIDTH-1:WIDTH];
            r_lo <= w_result[WIDTH-1:0];
        end
    end

    multu_shift_add_dp #(
        .WIDTH    (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .step     (w_step),
        .a_in     (w_op_a),
        .b_in     (w_op_b),
        .p_hi_nxt (w_p_hi_nxt),
        .p_lo_nxt (w_p_lo_nxt)
    );

    assign HiOut = r_hi;
    assign LoOut = r_lo;
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);

endmodule : hilo_multu_unit
`default_nettype wire

// File: tb/tb_hilo_multu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_multu_unit
// Description : Self-checking bench for hilo_multu_unit: directed vector
//               table, random MULTU against a plain-arithmetic product, and
//               hand-written sequences for busy-ignore, reset abort and
//               back-to-back issue. Honours MULT_SIGNED_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_multu_unit;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MFHI  = 6'b010000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_fail;
    logic [63:0] model_hilo;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic        acc;
    } vec_t;

    vec_t tv[9];

    hilo_multu_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .dataA (dataA),
        .dataB (dataB),
        .HiOut (HiOut),
        .LoOut (LoOut),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count RUN cycles (bounded) while confirming HI/LO hold the old result.
    task automatic wait_run(output int n, output logic held_ok);
        n = 0;
        held_ok = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if ({HiOut, LoOut} !== model_hilo) held_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Issue one command and check acceptance, latency, hold, result, done.
    task automatic do_cmd(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input logic acc);
        int   n;
        logic held_ok;
        @(negedge clk);
        start = 1'b1; funct = f; dataA = a; dataB = b;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0; dataA = $urandom; dataB = $urandom;
        if (!acc) begin
            chk({name, " ignored busy"}, {63'd0, busy}, 64'd0);
            chk({name, " ignored hilo"}, {HiOut, LoOut}, model_hilo);
            return;
        end
        wait_run(n, held_ok);
        chk({name, " run cycles"}, 64'(n), 64'd32);
        chk({name, " hilo held"}, {63'd0, held_ok}, 64'd1);
        chk({name, " done"}, {63'd0, done}, 64'd1);
        chk({name, " result"}, {HiOut, LoOut}, exp);
        model_hilo = exp;
        @(posedge clk); #1;
        chk({name, " done pulse end"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        held_ok;
        logic        bad;
        logic [31:0] ra;
        logic [31:0] rb;

        n_checks   = 0;
        n_fail     = 0;
        model_hilo = 64'd0;
        start = 1'b0; funct = 6'd0; dataA = 32'd0; dataB = 32'd0;

        tv[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1};
        tv[1] = '{F_MULTU, 32'd3,         32'd5,         64'h0000_0000_0000_000F, 1'b1};
        tv[2] = '{F_ADD,   32'd2,         32'd2,         64'h0000_0000_0000_000F, 1'b0};
        tv[3] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1};
        tv[4] = '{F_MULTU, 32'd0,         32'hDEAD_BEEF, 64'h0000_0000_0000_0000, 1'b1};
        tv[5] = '{F_MULTU, 32'h8000_0001, 32'd2,         64'h0000_0001_0000_0002, 1'b1};
        tv[6] = '{F_MULTU, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 1'b1};
`ifdef MULT_SIGNED_EN
        tv[7] = '{F_MULT,  32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA, 1'b1};
`else
        tv[7] = '{F_MULT,  32'hFFFF_FFFE, 32'd3,         64'h0000_0001_2345_6780, 1'b0};
`endif
        tv[8] = '{F_MFHI,  32'd9,         32'd9,         64'd0,                   1'b0};

        // Reset state, observed while reset is asserted.
        rst_n = 1'b0;
        #1;
        chk("reset hilo", {HiOut, LoOut}, 64'd0);
        chk("reset busy/done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            do_cmd($sformatf("vec%0d", i), tv[i].f, tv[i].a, tv[i].b,
                   tv[i].acc ? tv[i].exp : model_hilo, tv[i].acc);
        end

        // Random MULTU against a plain 64-bit product.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
            do_cmd($sformatf("rand%0d", i), F_MULTU, ra, rb, {32'd0, ra} * {32'd0, rb}, 1'b1);
        end

        // Second MULTU while busy is dropped; only the first result lands.
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; dataA = 32'd6; dataB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        held_ok = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            start = (n == 5);
            funct = F_MULTU; dataA = 32'd2; dataB = 32'd2;
            n++;
            if ({HiOut, LoOut} !== model_hilo) held_ok = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("busy-ignore run cycles", 64'(n), 64'd32);
        chk("busy-ignore hilo held", {63'd0, held_ok}, 64'd1);
        chk("busy-ignore result", {HiOut, LoOut}, 64'd42);
        model_hilo = 64'd42;
        @(posedge clk); #1;
        chk("busy-ignore no restart", {63'd0, busy}, 64'd0);

        // Back-to-back: new command accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; dataA = 32'd5; dataB = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        wait_run(n, held_ok);
        chk("b2b first cycles", 64'(n), 64'd32);
        chk("b2b first done", {63'd0, done}, 64'd1);
        chk("b2b first result", {HiOut, LoOut}, 64'd30);
        model_hilo = 64'd30;
        start = 1'b1; funct = F_MULTU; dataA = 32'h100; dataB = 32'h100;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b no idle busy", {62'd0, busy, done}, 64'd2);
        wait_run(n, held_ok);
        chk("b2b second cycles", 64'(n), 64'd32);
        chk("b2b second hilo held", {63'd0, held_ok}, 64'd1);
        chk("b2b second result", {HiOut, LoOut}, 64'h1_0000);
        model_hilo = 64'h1_0000;
        @(posedge clk); #1;

        // Reset mid-run: everything clears at once and no done follows.
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; dataA = 32'd7; dataB = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort hilo", {HiOut, LoOut}, 64'd0);
        chk("abort busy/done", {62'd0, busy, done}, 64'd0);
        model_hilo = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        chk("abort no done", {63'd0, bad}, 64'd0);
        chk("abort hilo stays", {HiOut, LoOut}, 64'd0);

        // Unit still works after the abort.
        do_cmd("post-abort", F_MULTU, 32'd7, 32'd9, 64'd63, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hilo_multu_unit
`default_nettype wire
